// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory fetch channel between fetch_pc_unit and instruction memory.
// Signals:
//   imem_req   - fetch request valid (fetch -> memory)
//   imem_addr  - word-aligned fetch address (fetch -> memory)
//   imem_ack   - memory returns imem_rdata this cycle (memory -> fetch)
//   imem_rdata - instruction word (memory -> fetch)
// Modports: master = fetch unit, slave = instruction memory.
interface fetch_pc_unit_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch stage.
// Holds the PC, issues word-aligned requests on the imem channel, and presents
// one fetched instruction per slot to decode with stall back-pressure, a
// one-entry skid register and flush-on-redirect (jump beats branch).
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   branch_taken_i    - branch redirect request, target branch_target_i
//   jump_i            - unconditional redirect, target jump_target_i
//   stall_i           - decode not accepting; output slot holds
//   imem              - fetch channel (master side)
//   instr_o           - fetched instruction (NOP_INSTR when slot empty)
//   instr_pc_o        - PC of instr_o
//   instr_valid_o     - output slot holds a valid instruction
//   misalign_trap_o   - only with PC_ALIGN_CHECK_EN: one-cycle pulse after an
//                       accepted redirect whose target was not word-aligned
// Build option: define PC_ALIGN_CHECK_EN to add misalign_trap_o.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   branch_taken_i,
    input  logic [31:0]            branch_target_i,
    input  logic                   jump_i,
    input  logic [31:0]            jump_target_i,
    input  logic                   stall_i,
    fetch_pc_unit_if.master        imem,
    output logic [31:0]            instr_o,
    output logic [31:0]            instr_pc_o,
`ifdef PC_ALIGN_CHECK_EN
    output logic                   misalign_trap_o,
`endif
    output logic                   instr_valid_o
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            skid_vld_q, skid_vld_d;

    logic            redirect;
    logic [XLEN-1:0] redirect_raw;
    logic [XLEN-1:0] redirect_tgt;
    logic            consumed;
    logic [XLEN-1:0] pc_inc;

    // Redirect selection; jump wins, low bits always forced to zero.
    assign redirect     = jump_i | branch_taken_i;
    assign redirect_raw = jump_i ? jump_target_i : branch_target_i;
    assign redirect_tgt = redirect_raw & ~XLEN'(3);
    assign consumed     = valid_q & ~stall_i;
    assign pc_inc       = pc_q + XLEN'(4);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_VECTOR;
            req_q        <= 1'b0;
            pend_q       <= 1'b0;
            pend_tgt_q   <= '0;
            instr_q      <= NOP_INSTR;
            instr_pc_q   <= '0;
            valid_q      <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            pend_q       <= pend_d;
            pend_tgt_q   <= pend_tgt_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_vld_q   <= skid_vld_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        pend_tgt_d   = pend_tgt_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_vld_d   = skid_vld_q;

        case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                if (imem.imem_ack) begin
                    if (redirect || pend_q) begin
                        // Returned word belongs to the wrong path: drop it.
                        pc_d    = redirect ? redirect_tgt : pend_tgt_q;
                        pend_d  = 1'b0;
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                    end else if (!valid_q || consumed) begin
                        instr_d    = imem.imem_rdata;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        pc_d       = pc_inc;
                    end else begin
                        // Slot full and stalled: park the word and stop fetching.
                        skid_instr_d = imem.imem_rdata;
                        skid_pc_d    = pc_q;
                        skid_vld_d   = 1'b1;
                        pc_d         = pc_inc;
                        state_d      = S_HOLD;
                    end
                end else if (redirect) begin
                    // Request must stay stable; remember where to go once acked.
                    pend_d     = 1'b1;
                    pend_tgt_d = redirect_tgt;
                    valid_d    = 1'b0;
                    instr_d    = NOP_INSTR;
                end else if (consumed) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    valid_d    = 1'b0;
                    instr_d    = NOP_INSTR;
                    skid_vld_d = 1'b0;
                    pc_d       = redirect_tgt;
                    state_d    = S_REQ;
                end else if (!stall_i) begin
                    if (skid_vld_q) begin
                        instr_d    = skid_instr_q;
                        instr_pc_d = skid_pc_q;
                        valid_d    = 1'b1;
                    end
                    skid_vld_d = 1'b0;
                    state_d    = S_REQ;
                end
            end

            default: begin
                state_d = S_BOOT;
            end
        endcase

        req_d = (state_d == S_REQ);
    end

`ifdef PC_ALIGN_CHECK_EN
    logic trap_q;

    // Flag accepted redirects whose target had non-zero low bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= redirect && (state_q != S_BOOT) && (redirect_raw[1:0] != 2'b00);
        end
    end

    assign misalign_trap_o = trap_q;
`endif

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr_o        = instr_q;
    assign instr_pc_o     = instr_pc_q;
    assign instr_valid_o  = valid_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed testbench for fetch_pc_unit. Memory returns addr ^ 32'hDEAD_0000.
module tb_fetch_pc_unit;
    logic        clk;
    logic        rst;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_trap;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_pc_unit_if bus();

    assign bus.imem_rdata = bus.imem_addr ^ 32'hDEAD_0000;

    fetch_pc_unit dut (
        .clk             (clk),
        .rst             (rst),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .stall_i         (stall),
        .imem            (bus),
        .instr_o         (instr),
        .instr_pc_o      (instr_pc),
`ifdef PC_ALIGN_CHECK_EN
        .misalign_trap_o (misalign_trap),
`endif
        .instr_valid_o   (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst           = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        stall         = 1'b0;
        bus.imem_ack  = 1'b0;
        tick();
        tick();
        chk("rst_req",   32'(bus.imem_req), 32'd0);
        chk("rst_addr",  bus.imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_ipc",   instr_pc, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
`ifdef PC_ALIGN_CHECK_EN
        chk("rst_trap",  32'(misalign_trap), 32'd0);
`endif

        // Streaming with ack tied high.
        rst = 1'b0;
        bus.imem_ack = 1'b1;
        tick();
        chk("boot_req",   32'(bus.imem_req), 32'd1);
        chk("boot_addr",  bus.imem_addr, 32'h0);
        chk("boot_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("s1_addr",  bus.imem_addr, 32'h4);
        chk("s1_valid", 32'(instr_valid), 32'd1);
        chk("s1_ipc",   instr_pc, 32'h0);
        chk("s1_instr", instr, 32'hDEAD_0000);
        tick();
        chk("s2_addr", bus.imem_addr, 32'h8);
        chk("s2_ipc",  instr_pc, 32'h4);
        tick();
        chk("s3_addr", bus.imem_addr, 32'hC);
        chk("s3_ipc",  instr_pc, 32'h8);
        tick();
        chk("s4_addr", bus.imem_addr, 32'h10);
        chk("s4_ipc",  instr_pc, 32'hC);

        // Ack delayed three cycles at 0x10.
        bus.imem_ack = 1'b0;
        tick();
        chk("d1_addr",  bus.imem_addr, 32'h10);
        chk("d1_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("d2_addr", bus.imem_addr, 32'h10);
        tick();
        chk("d3_addr", bus.imem_addr, 32'h10);
        chk("d3_req",  32'(bus.imem_req), 32'd1);
        bus.imem_ack = 1'b1;
        tick();
        chk("d_ack_ipc",   instr_pc, 32'h10);
        chk("d_ack_valid", 32'(instr_valid), 32'd1);
        chk("d_ack_addr",  bus.imem_addr, 32'h14);
        tick();
        tick();
        tick();
        chk("w_addr", bus.imem_addr, 32'h20);
        chk("w_ipc",  instr_pc, 32'h1C);

        // Branch while waiting at 0x20: remembered, then word discarded.
        bus.imem_ack  = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h80;
        tick();
        chk("br_pend_addr",  bus.imem_addr, 32'h20);
        chk("br_pend_valid", 32'(instr_valid), 32'd0);
        chk("br_pend_instr", instr, 32'h0000_0013);
        branch_taken = 1'b0;
        bus.imem_ack = 1'b1;
        tick();
        chk("br_disc_addr",  bus.imem_addr, 32'h80);
        chk("br_disc_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("br_tgt_ipc",   instr_pc, 32'h80);
        chk("br_tgt_instr", instr, 32'hDEAD_0080);
        chk("br_tgt_addr",  bus.imem_addr, 32'h84);

        // Jump and branch together: jump wins.
        jump          = 1'b1;
        jump_target   = 32'h200;
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        tick();
        chk("jb_addr",  bus.imem_addr, 32'h200);
        chk("jb_valid", 32'(instr_valid), 32'd0);
        jump         = 1'b0;
        branch_taken = 1'b0;
        tick();
        chk("jb_ipc", instr_pc, 32'h200);

        // Stall with full slot while 0x8 is acked.
        jump        = 1'b1;
        jump_target = 32'h4;
        tick();
        chk("st_jaddr", bus.imem_addr, 32'h4);
        jump  = 1'b0;
        stall = 1'b1;
        tick();
        chk("st_ipc4", instr_pc, 32'h4);
        chk("st_addr8", bus.imem_addr, 32'h8);
        tick();
        chk("hold_req",  32'(bus.imem_req), 32'd0);
        chk("hold_addr", bus.imem_addr, 32'hC);
        chk("hold_ipc",  instr_pc, 32'h4);
        bus.imem_ack = 1'b0;
        tick();
        chk("hold2_req", 32'(bus.imem_req), 32'd0);
        chk("hold2_ipc", instr_pc, 32'h4);
        stall = 1'b0;
        tick();
        chk("drain_ipc",   instr_pc, 32'h8);
        chk("drain_instr", instr, 32'hDEAD_0008);
        chk("drain_valid", 32'(instr_valid), 32'd1);
        chk("drain_req",   32'(bus.imem_req), 32'd1);
        chk("drain_addr",  bus.imem_addr, 32'hC);
        tick();
        chk("cons_valid", 32'(instr_valid), 32'd0);

        // PC wrap at the top of the address space.
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        tick();
        jump         = 1'b0;
        bus.imem_ack = 1'b1;
        tick();
        chk("wrap_top", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr",  bus.imem_addr, 32'h0);
        chk("wrap_ipc",   instr_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", instr, 32'h2152_FFFC);

        // Misaligned jump target: low bits cleared.
        bus.imem_ack = 1'b0;
        jump         = 1'b1;
        jump_target  = 32'h103;
        tick();
`ifdef PC_ALIGN_CHECK_EN
        chk("trap_hi", 32'(misalign_trap), 32'd1);
`endif
        jump         = 1'b0;
        bus.imem_ack = 1'b1;
        tick();
        chk("mis_addr", bus.imem_addr, 32'h100);
`ifdef PC_ALIGN_CHECK_EN
        chk("trap_lo", 32'(misalign_trap), 32'd0);
`endif

        // Reset during an outstanding request.
        bus.imem_ack = 1'b0;
        rst          = 1'b1;
        tick();
        chk("rst2_req",   32'(bus.imem_req), 32'd0);
        chk("rst2_addr",  bus.imem_addr, 32'h0);
        chk("rst2_valid", 32'(instr_valid), 32'd0);
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Program-counter and instruction-fetch stage that consumes the branch decision (b_out) from branch_logic and the jump/target info from decode/execute. It holds the PC and issues word-aligned requests to instruction memory over a req/ack handshake. It presents one fetched instruction per slot to decode, with stall back-pressure and flush-on-redirect.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, value driven on instr when the slot is empty/reset (addi x0,x0,0)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
branch_taken  input  1  b_out from branch_logic; redirect to branch_target
branch_target  input  32  branch destination address
jump  input  1  unconditional redirect (JAL/JALR); priority over branch_taken
jump_target  input  32  jump destination address
stall  input  1  decode not accepting; output slot must hold
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address, word-aligned
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  instruction word
instr  output  32  fetched instruction to decode
instr_pc  output  32  PC of instr
instr_valid  output  1  output slot holds a valid instruction

Behaviour:
- One clock (clk); reset synchronous, active-high (rst); rst has priority over every other input.
- Reset values: pc=RESET_VECTOR, state=BOOT, imem_req=0, imem_addr=RESET_VECTOR, instr=NOP_INSTR, instr_pc=0, instr_valid=0, skid empty, redirect-pending clear.
- redirect = jump | branch_taken; target = jump ? jump_target : branch_target; target[1:0] forced to 2'b00.
- Slot is consumed in a cycle when instr_valid=1 and stall=0.
- States: BOOT, REQ, HOLD.
- BOOT: imem_req=0; always goes to REQ next cycle (first request one cycle after rst deasserts).
- REQ: imem_req=1, imem_addr=pc.
  - pc/imem_addr are held stable until imem_ack; a request is never withdrawn except by rst.
  - No ack and redirect: set pend, store target (a later redirect overwrites); instr_valid<=0 next cycle.
  - Ack with redirect this cycle or pend set: discard rdata; pc<=target (this-cycle redirect beats pend); clear pend; instr_valid<=0; stay REQ.
  - Ack, no redirect, slot empty or consumed: instr<=rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4; stay REQ. Fetch latency is ack to instr_valid, 1 cycle.
  - Ack, no redirect, slot valid and stall=1: rdata/pc go to the skid register; pc<=pc+4; go HOLD.
  - No ack and slot consumed: instr_valid<=0.
- HOLD: imem_req=0.
  - redirect: flush slot and skid, instr_valid<=0, pc<=target, go REQ.
  - stall=0: slot<=skid, instr_valid=1, go REQ.
  - stall=1: hold everything.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- instr shows NOP_INSTR whenever instr_valid=0 after a flush.
- rst during an outstanding request abandons it; imem_req=0 the cycle after.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined: adds output port misalign_trap (1 bit, reset 0). It pulses high for one cycle, registered, in the cycle after any accepted redirect whose target[1:0]!=0. The redirect still proceeds with the low bits cleared.
- Undefined: port absent; low bits cleared silently.

Test Plan:
- Reset release, imem_ack tied high, stall=0 -> imem_addr 0,4,8 on consecutive cycles; instr_valid=1 from cycle 2 with instr_pc 0,4,8.
- Ack delayed 3 cycles at addr 0x10 -> imem_addr holds 0x10 all 3 cycles; instr_pc=0x10 one cycle after ack; pc becomes 0x14.
- branch_taken=1, branch_target=0x80 while waiting for ack at 0x20 -> returned word discarded, instr_valid=0, next imem_addr=0x80.
- jump=1 (jump_target=0x200) and branch_taken=1 (branch_target=0x100) same cycle -> next imem_addr=0x200.
- stall=1 with slot full, ack at 0x8 -> state HOLD, imem_req=0; stall drops -> instr_pc=0x8 presented, next request addr 0xC.
- PC at 0xFFFF_FFFC, ack -> next imem_addr=0x0. With PC_ALIGN_CHECK_EN, jump_target=0x103 -> misalign_trap pulses one cycle, imem_addr=0x100.
